iob_reg_wr_arb: RTL and testbench

//   Round-robin write arbiter owning one shared DATA_W register.

---
 rtl/iob_reg_wr_arb.sv | 139 +++++++++++++
 tb/tb_iob_reg_wr_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_reg_wr_arb.sv
// Round-robin write arbiter that owns one shared register.
// Requesters update the register through valid/ready handshakes, one write per grant.
module iob_reg_wr_arb #(
    parameter int unsigned          N_REQ    = 4,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [DATA_W-1:0]    RST_VAL  = '0,
    parameter int unsigned          HOLD_CYC = 0
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      clr_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic [DATA_W-1:0]         data_o,
    output logic                      data_valid_o
);

    localparam int unsigned      IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       HOLD_LAST = 8'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_HOLD
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   g_q;
    logic [7:0]         cnt_q;
    logic [DATA_W-1:0]  data_q;
    logic               dv_q;
    logic [N_REQ-1:0]   grant_q;

    logic [IDX_W-1:0]   pick_d;
    logic               found;
    int unsigned        idx;
    logic               sel_valid;
    logic [DATA_W-1:0]  sel_data;
    logic [IDX_W-1:0]   ptr_d;

    // First requesting index scanning from ptr_q upward, wrapping.
    always_comb begin
        pick_d = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid_i[IDX_W'(idx)]) begin
                found  = 1'b1;
                pick_d = IDX_W'(idx);
            end
        end
    end

    // Valid and data of the latched owner.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (IDX_W'(k) == g_q) begin
                sel_valid = req_valid_i[IDX_W'(k)];
                sel_data  = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_d = (g_q == IDX_LAST) ? '0 : g_q + IDX_W'(1);

    // Ready follows the owner's valid combinationally; clear suppresses the handshake.
    assign req_ready_o = (state_q == ST_WRITE && !clr_i && sel_valid) ? grant_q : '0;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            data_q  <= RST_VAL;
            dv_q    <= 1'b0;
            grant_q <= '0;
        end else if (clr_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            data_q  <= RST_VAL;
            dv_q    <= 1'b0;
            grant_q <= '0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        g_q     <= pick_d;
                        grant_q <= N_REQ'(1) << pick_d;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                    if (sel_valid) begin
                        data_q <= sel_data;
                        dv_q   <= 1'b1;
                        ptr_q  <= ptr_d;
                        cnt_q  <= '0;
                        if (HOLD_CYC > 0) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign data_o       = data_q;
    assign data_valid_o = dv_q;

endmodule

// File: tb/tb_iob_reg_wr_arb.sv
// Bench for iob_reg_wr_arb: instance 0 has no hold, instance 1 holds 3 cycles.
// A cycle-level model is compared on every falling edge; directed checks pin key cases.
module tb_iob_reg_wr_arb;

    localparam int HOLD_B = 3;

    logic                  clk_i;
    logic [1:0]            rst_n;
    logic [1:0]            clr;
    logic [1:0][3:0]       vld;
    logic [1:0][127:0]     dat;
    logic [1:0][3:0]       rdy;
    logic [1:0][3:0]       gnt;
    logic [1:0][31:0]      dout;
    logic [1:0]            dvo;

    int total = 0;
    int bad   = 0;

    int          m_own  [2];
    int          m_cool [2];
    int          m_ptr  [2];
    logic [31:0] m_data [2];
    logic        m_dv   [2];
    int          hold_c [2];

    iob_reg_wr_arb #(.N_REQ(4), .DATA_W(32), .RST_VAL(32'd5), .HOLD_CYC(0)) u_a (
        .clk_i(clk_i), .arst_n_i(rst_n[0]), .clr_i(clr[0]),
        .req_valid_i(vld[0]), .req_data_i(dat[0]),
        .req_ready_o(rdy[0]), .grant_o(gnt[0]),
        .data_o(dout[0]), .data_valid_o(dvo[0])
    );

    iob_reg_wr_arb #(.N_REQ(4), .DATA_W(32), .RST_VAL(32'd5), .HOLD_CYC(HOLD_B)) u_b (
        .clk_i(clk_i), .arst_n_i(rst_n[1]), .clr_i(clr[1]),
        .req_valid_i(vld[1]), .req_data_i(dat[1]),
        .req_ready_o(rdy[1]), .grant_o(gnt[1]),
        .data_o(dout[1]), .data_valid_o(dvo[1])
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset(input int d);
        m_own[d]  = -1;
        m_cool[d] = 0;
        m_ptr[d]  = 0;
        m_data[d] = 32'd5;
        m_dv[d]   = 1'b0;
    endtask

    // One clock of the model: owner = requester granted this cycle, cool = hold cycles left.
    task automatic mstep(input int d);
        logic nd;
        int   k;
        if (!rst_n[d] || clr[d]) begin
            mreset(d);
        end else begin
            nd = 1'b0;
            if (m_own[d] >= 0) begin
                if (vld[d][m_own[d]]) begin
                    m_data[d] = dat[d][m_own[d]*32 +: 32];
                    nd        = 1'b1;
                    m_ptr[d]  = (m_own[d] + 1) % 4;
                    m_cool[d] = hold_c[d];
                end
                m_own[d] = -1;
            end else if (m_cool[d] > 0) begin
                m_cool[d] = m_cool[d] - 1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    k = (m_ptr[d] + i) % 4;
                    if (m_own[d] < 0 && vld[d][k]) m_own[d] = k;
                end
            end
            m_dv[d] = nd;
        end
    endtask

    initial begin : model_cmp
        logic [3:0] eg;
        logic [3:0] er;
        hold_c[0] = 0;
        hold_c[1] = HOLD_B;
        mreset(0);
        mreset(1);
        forever begin
            @(negedge clk_i);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n[d]) mreset(d);
                eg = (m_own[d] >= 0) ? 4'(1 << m_own[d]) : 4'b0;
                er = (m_own[d] >= 0 && !clr[d] && vld[d][m_own[d]]) ? eg : 4'b0;
                chk($sformatf("m%0d_grant", d), 128'(gnt[d]), 128'(eg));
                chk($sformatf("m%0d_ready", d), 128'(rdy[d]), 128'(er));
                chk($sformatf("m%0d_data", d), 128'(dout[d]), 128'(m_data[d]));
                chk($sformatf("m%0d_dvalid", d), 128'(dvo[d]), 128'(m_dv[d]));
            end
            @(posedge clk_i);
            for (int d = 0; d < 2; d++) mstep(d);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    int         q_val [$];
    int         q_cyc [$];
    int         r_cyc [$];
    logic [3:0] r_rdy [$];
    logic [3:0] pend;

    initial begin : stim
        rst_n = '1;
        clr   = '0;
        vld   = '0;
        dat   = '0;
        #2 rst_n = '0;
        tick(2);
        // reset state
        chk("rst_data", 128'(dout[0]), 128'd5);
        chk("rst_ready", 128'(rdy[0]), 128'd0);
        chk("rst_grant", 128'(gnt[0]), 128'd0);
        chk("rst_dvalid", 128'(dvo[0]), 128'd0);
        rst_n = '1;
        tick(2);
        chk("idle_data", 128'(dout[0]), 128'd5);
        chk("idle_grant", 128'(gnt[0]), 128'd0);

        // single request from requester 2
        dat[0][2*32 +: 32] = 32'hA5;
        vld[0] = 4'b0100;
        tick(1);
        chk("r2_ready", 128'(rdy[0]), 128'h4);
        chk("r2_grant", 128'(gnt[0]), 128'h4);
        tick(1);
        vld[0] = 4'b0000;
        chk("r2_data", 128'(dout[0]), 128'hA5);
        chk("r2_dvalid", 128'(dvo[0]), 128'd1);
        tick(1);
        chk("r2_pulse_end", 128'(dvo[0]), 128'd0);

        // pointer now 3: requester 3 wins over 0, then 0
        dat[0][3*32 +: 32] = 32'h33;
        dat[0][0*32 +: 32] = 32'h44;
        vld[0] = 4'b1001;
        tick(1);
        chk("ptr3_grant", 128'(gnt[0]), 128'h8);
        tick(1);
        vld[0] = 4'b0001;
        chk("ptr3_data", 128'(dout[0]), 128'h33);
        tick(1);
        chk("ptr0_grant", 128'(gnt[0]), 128'h1);
        tick(1);
        vld[0] = 4'b0000;
        chk("ptr0_data", 128'(dout[0]), 128'h44);
        tick(1);

        // requester 1 withdraws in WRITE
        dat[0][1*32 +: 32] = 32'h11;
        vld[0] = 4'b0010;
        tick(1);
        vld[0] = 4'b0000;
        #1;
        chk("wd_ready", 128'(rdy[0]), 128'd0);
        chk("wd_grant", 128'(gnt[0]), 128'h2);
        tick(1);
        chk("wd_data", 128'(dout[0]), 128'h44);
        chk("wd_dvalid", 128'(dvo[0]), 128'd0);
        vld[0] = 4'b0011;
        tick(1);
        chk("wd_ptr_kept", 128'(gnt[0]), 128'h2);
        tick(1);
        vld[0] = 4'b0001;
        tick(2);
        vld[0] = 4'b0000;
        tick(1);

        // clear during WRITE of requester 0
        dat[0][0*32 +: 32] = 32'h55;
        vld[0] = 4'b0001;
        tick(1);
        clr[0] = 1'b1;
        #1;
        chk("clr_ready", 128'(rdy[0]), 128'd0);
        tick(1);
        clr[0] = 1'b0;
        chk("clr_data", 128'(dout[0]), 128'd5);
        chk("clr_dvalid", 128'(dvo[0]), 128'd0);
        vld[0] = 4'b1111;
        tick(1);
        chk("clr_next_grant", 128'(gnt[0]), 128'h1);
        tick(1);
        vld[0] = 4'b0000;
        tick(1);

        // all four requesting constantly after a clear
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        dat[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        vld[0] = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (dvo[0]) begin
                q_val.push_back(int'(dout[0]));
                q_cyc.push_back(c);
            end
        end
        vld[0] = 4'b0000;
        chk("rr_count", 128'(q_val.size()), 128'd6);
        if (q_val.size() >= 5) begin
            chk("rr_w0", 128'(q_val[0]), 128'd1);
            chk("rr_w1", 128'(q_val[1]), 128'd2);
            chk("rr_w2", 128'(q_val[2]), 128'd3);
            chk("rr_w3", 128'(q_val[3]), 128'd4);
            chk("rr_w4", 128'(q_val[4]), 128'd1);
            chk("rr_spacing", 128'(q_cyc[4] - q_cyc[0]), 128'd8);
        end
        tick(2);

        // hold of 3: back-to-back requests from 0 and 1
        pend = 4'b0000;
        vld[1] = 4'b0011;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            vld[1] = vld[1] & ~pend;
            #1;
            pend = rdy[1];
            if (rdy[1] != 4'b0000) begin
                r_cyc.push_back(c);
                r_rdy.push_back(rdy[1]);
            end
        end
        chk("hold_count", 128'(r_cyc.size()), 128'd2);
        if (r_cyc.size() == 2) begin
            chk("hold_first", 128'(r_rdy[0]), 128'h1);
            chk("hold_second", 128'(r_rdy[1]), 128'h2);
            chk("hold_gap", 128'(r_cyc[1] - r_cyc[0]), 128'd5);
        end
        vld[1] = 4'b0000;
        tick(2);

        // async reset during HOLD
        dat[1][2*32 +: 32] = 32'h77;
        vld[1] = 4'b0100;
        tick(2);
        vld[1] = 4'b0000;
        chk("ar_pre_data", 128'(dout[1]), 128'h77);
        tick(1);
        rst_n[1] = 1'b0;
        #1;
        chk("ar_data", 128'(dout[1]), 128'd5);
        chk("ar_grant", 128'(gnt[1]), 128'd0);
        chk("ar_dvalid", 128'(dvo[1]), 128'd0);
        tick(1);
        rst_n[1] = 1'b1;
        vld[1] = 4'b1111;
        tick(1);
        chk("ar_restart_grant", 128'(gnt[1]), 128'h1);
        tick(1);
        vld[1] = 4'b0000;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
